shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift1_unit.sv | 24 ++
 rtl/shift_sequencer.sv | 89 ++++++++
 tb/tb_shift_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer and ALU decode: op codes, FSM states, default widths.
package shift_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int AMT_W_DEF = 5;

   // 3'b101..3'b111 all decode as PASS
   typedef enum logic [2:0] {
      OP_SHL  = 3'b000,
      OP_SHR  = 3'b001,
      OP_SHRA = 3'b010,
      OP_ROL  = 3'b011,
      OP_ROR  = 3'b100,
      OP_PASS = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift1_unit.sv
// Combinational one-bit shift/rotate step; unknown op codes pass the value through unchanged.
module shift1_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] next_value_o
);

   always_comb begin
      next_value_o = value_i;
      case (op_i)
         OP_SHL:  next_value_o = {value_i[WIDTH-2:0], 1'b0};
         OP_SHR:  next_value_o = {1'b0, value_i[WIDTH-1:1]};
         OP_SHRA: next_value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
         OP_ROL:  next_value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
         OP_ROR:  next_value_o = {value_i[0], value_i[WIDTH-1:1]};
         default: next_value_o = value_i;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit per clock for num_shifts mod 2**AMT_W steps, then a one-cycle done strobe.
// start is only sampled in IDLE; busy and done are registered so no input reaches an output combinationally.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AMT_W = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic [31:0]      num_shifts,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_e             state_q;
   logic [WIDTH-1:0]   result_q;
   logic [WIDTH-1:0]   result_d;
   logic [AMT_W-1:0]   count_q;
   logic [2:0]         op_q;
   logic               busy_q;
   logic               done_q;

   // Only the low AMT_W bits of the count matter; multiples of 2**AMT_W act as zero.
   logic unused_ns_hi;
   assign unused_ns_hi = ^num_shifts[31:AMT_W];

   shift1_unit #(.WIDTH(WIDTH)) u_shift1 (
      .value_i      (result_q),
      .op_i         (op_q),
      .next_value_o (result_d)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         count_q  <= '0;
         op_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  result_q <= operand;
                  op_q     <= op;
                  count_q  <= num_shifts[AMT_W-1:0];
                  busy_q   <= 1'b1;
                  if (num_shifts[AMT_W-1:0] != '0) begin
                     state_q <= ST_SHIFT;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               result_q <= result_d;
               count_q  <= count_q - AMT_W'(1);
               if (count_q == AMT_W'(1)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed scenarios plus random operations checked against an arithmetic shift/rotate model.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [2:0]  op;
   logic [31:0] operand;
   logic [31:0] num_shifts;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .op         (op),
      .operand    (operand),
      .num_shifts (num_shifts),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 clk = ~clk;

   // Whole-operation result from the count, not from single-bit steps.
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] v, input int k);
      if (k == 0) return v;
      case (o)
         3'd0:    return v << k;
         3'd1:    return v >> k;
         3'd2:    return 32'($signed(v) >>> k);
         3'd3:    return (v << k) | (v >> (32 - k));
         3'd4:    return (v >> k) | (v << (32 - k));
         default: return v;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts one operation and checks busy/done every cycle up to done, then the result and its hold in IDLE.
   task automatic run_op(input logic [2:0] o, input logic [31:0] v, input logic [31:0] n, input bit repulse);
      int          k;
      logic [31:0] exp;
      k   = int'(n % 32);
      exp = model(o, v, k);
      @(negedge clk);
      start = 1'b1; op = o; operand = v; num_shifts = n;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); operand = $urandom; num_shifts = $urandom;
      for (int c = 1; c <= k + 1; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         if (repulse && c == 1 && k >= 2) begin
            start = 1'b1; operand = 32'hFFFF_FFFF;
         end
         if (repulse && c == 2) start = 1'b0;
         check("busy_active", {31'b0, busy}, 32'd1);
         check("done_timing", {31'b0, done}, (c == k + 1) ? 32'd1 : 32'd0);
      end
      check("result", result, exp);
      @(posedge clk); #1;
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_done", {31'b0, done}, 32'd0);
      check("result_hold", result, exp);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; op = 3'd0; operand = 32'h0; num_shifts = 32'h0;
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) clr = 1'b0;

      run_op(3'd3, 32'h8000_0001, 32'd1, 1'b0);
      run_op(3'd4, 32'h0000_0001, 32'd4, 1'b0);
      run_op(3'd2, 32'h8000_0000, 32'd31, 1'b0);
      run_op(3'd1, 32'h8000_0000, 32'd31, 1'b0);
      run_op(3'd0, 32'h1234_5678, 32'h20, 1'b0);
      run_op(3'd3, 32'h1234_5678, 32'h40, 1'b0);
      run_op(3'd0, 32'h0000_0001, 32'd5, 1'b1);
      run_op(3'd6, 32'hDEAD_BEEF, 32'd7, 1'b0);

      // start held high: second operation must begin in the IDLE cycle right after DONE
      @(negedge clk);
      start = 1'b1; op = 3'd0; operand = 32'h1; num_shifts = 32'd1;
      @(posedge clk); #1;
      check("hold_c1_busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      check("hold_c2_done", {31'b0, done}, 32'd1);
      check("hold_c2_result", result, 32'h2);
      @(posedge clk); #1;
      check("hold_c3_idle", {31'b0, busy}, 32'd0);
      operand = 32'h5; num_shifts = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_c4_busy", {31'b0, busy}, 32'd1);
      check("hold_c4_done", {31'b0, done}, 32'd1);
      check("hold_c4_result", result, 32'h5);
      @(posedge clk); #1;

      // clr during the third SHIFT cycle of an SHL by 10
      @(negedge clk);
      start = 1'b1; op = 3'd0; operand = 32'h0000_0F0F; num_shifts = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("pre_clr_busy", {31'b0, busy}, 32'd1);
      #2 clr = 1'b1;
      #1;
      check("clr_busy", {31'b0, busy}, 32'd0);
      check("clr_done", {31'b0, done}, 32'd0);
      check("clr_result", result, 32'd0);
      @(posedge clk);
      @(negedge clk) clr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("post_clr_no_done", {30'b0, busy, done}, 32'd0);
      end
      run_op(3'd0, 32'h0000_0001, 32'd2, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] n;
         n = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 33));
         run_op(3'($urandom_range(0, 7)), $urandom, n, bit'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
